// File: rtl/brlite_svc_fifo.sv
`default_nettype none
// ============================================================================
// brlite_svc_fifo : filters BrLite broadcast service packets and queues them
//                   for the DMNI service-receive port.
// Revision        : 1.0
// ============================================================================

package brlite_svc_pkg;
  typedef struct packed {
    logic [7:0]  ksvc;
    logic [15:0] seq_source;
    logic [15:0] producer;
    logic [31:0] payload;
  } brlite_svc_t;
endpackage

module brlite_svc_fifo
  import brlite_svc_pkg::*;
#(
  parameter int          BUFFER_SZ = 8,
  parameter logic [15:0] ADDRESS   = 16'h0000
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       br_req_i,
  output logic                       br_ack_o,
  input  logic [1:0]                 br_service_i,
  input  logic [7:0]                 br_ksvc_i,
  input  logic [15:0]                br_target_i,
  input  logic [15:0]                br_seq_source_i,
  input  logic [15:0]                br_producer_i,
  input  logic [31:0]                br_payload_i,
  output logic                       br_svc_rx_o,
  input  logic                       br_svc_ack_i,
  output brlite_svc_t                br_svc_data_o,
  output logic [$clog2(BUFFER_SZ):0] level_o,
  output logic [15:0]                drop_cnt_o
);

  localparam int                 c_PTR_W   = $clog2(BUFFER_SZ);
  localparam int                 c_CNT_W   = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(BUFFER_SZ);
  localparam logic [1:0]         c_SVC_ALL = 2'd0;
  localparam logic [1:0]         c_SVC_TGT = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACK      = 2'd1,
    S_WAIT_LOW = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_ack;
  logic                 r_rx;
  brlite_svc_t          r_data;
  logic [15:0]          r_drop_cnt;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_CNT_W-1:0]   r_count;
  brlite_svc_t          r_mem [BUFFER_SZ];

  brlite_svc_t          w_entry;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_pop;
  logic [c_PTR_W-1:0]   w_rd_ptr_nxt;
  logic [c_CNT_W-1:0]   w_count_nxt;
  brlite_svc_t          w_head;

  always_comb begin
    w_entry.ksvc       = br_ksvc_i;
    w_entry.seq_source = br_seq_source_i;
    w_entry.producer   = br_producer_i;
    w_entry.payload    = br_payload_i;
  end

  assign w_accept = (br_service_i == c_SVC_ALL) ||
                    ((br_service_i == c_SVC_TGT) && (br_target_i == ADDRESS));

  // Full blocks only accepted packets; drops are acked regardless of level.
  assign w_push = (r_state == S_IDLE) && br_req_i && w_accept && (r_count < c_DEPTH);
  assign w_drop = (r_state == S_IDLE) && br_req_i && !w_accept;
  assign w_pop  = br_svc_ack_i && (r_count != '0);

  assign w_rd_ptr_nxt = r_rd_ptr + c_PTR_W'(w_pop);
  assign w_count_nxt  = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

  // New head may be the entry being written this edge (empty, or last one popped).
  assign w_head = (w_push && (r_wr_ptr == w_rd_ptr_nxt)) ? w_entry : r_mem[w_rd_ptr_nxt];

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_ack      <= 1'b0;
      r_rx       <= 1'b0;
      r_data     <= '0;
      r_drop_cnt <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_rx     <= (w_count_nxt != '0);
      r_data   <= w_head;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_push || w_drop) begin
            r_state <= S_ACK;
            r_ack   <= 1'b1;
          end
        end
        S_ACK: begin
          r_state <= S_WAIT_LOW;
          r_ack   <= 1'b0;
        end
        S_WAIT_LOW: begin
          if (!br_req_i) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  assign br_ack_o      = r_ack;
  assign br_svc_rx_o   = r_rx;
  assign br_svc_data_o = r_data;
  assign level_o       = r_count;
  assign drop_cnt_o    = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_brlite_svc_fifo.sv
`default_nettype none
// ============================================================================
// tb_brlite_svc_fifo : scoreboard bench for brlite_svc_fifo
// Revision           : 1.0
// ============================================================================

module tb_brlite_svc_fifo;
  import brlite_svc_pkg::*;

  localparam int          BUFSZ = 8;
  localparam logic [15:0] ADDR  = 16'h0042;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        br_req_i = 1'b0;
  logic        br_ack_o;
  logic [1:0]  br_service_i = '0;
  logic [7:0]  br_ksvc_i = '0;
  logic [15:0] br_target_i = '0;
  logic [15:0] br_seq_source_i = '0;
  logic [15:0] br_producer_i = '0;
  logic [31:0] br_payload_i = '0;
  logic        br_svc_rx_o;
  logic        br_svc_ack_i = 1'b0;
  brlite_svc_t br_svc_data_o;
  logic [3:0]  level_o;
  logic [15:0] drop_cnt_o;

  brlite_svc_fifo #(.BUFFER_SZ(BUFSZ), .ADDRESS(ADDR)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .br_req_i        (br_req_i),
    .br_ack_o        (br_ack_o),
    .br_service_i    (br_service_i),
    .br_ksvc_i       (br_ksvc_i),
    .br_target_i     (br_target_i),
    .br_seq_source_i (br_seq_source_i),
    .br_producer_i   (br_producer_i),
    .br_payload_i    (br_payload_i),
    .br_svc_rx_o     (br_svc_rx_o),
    .br_svc_ack_i    (br_svc_ack_i),
    .br_svc_data_o   (br_svc_data_o),
    .level_o         (level_o),
    .drop_cnt_o      (drop_cnt_o)
  );

  always #5 clk = ~clk;

  brlite_svc_t exp_q[$];
  brlite_svc_t mon_e;
  int          n_err = 0;
  int          n_chk = 0;
  int          exp_drop = 0;
  bit          got;
  int          cyc;
  bit          done = 1'b0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit accepts(input logic [1:0] svc, input logic [15:0] tgt);
    return (svc == 2'd0) || (svc == 2'd1 && tgt == ADDR);
  endfunction

  // Drive a packet and record what the buffer must eventually hand out.
  task automatic raise(input logic [1:0] svc, input logic [15:0] tgt, input logic [7:0] k,
                       input logic [15:0] ss, input logic [15:0] pr, input logic [31:0] pl);
    brlite_svc_t e;
    br_service_i = svc; br_target_i = tgt; br_ksvc_i = k;
    br_seq_source_i = ss; br_producer_i = pr; br_payload_i = pl;
    br_req_i = 1'b1;
    e.ksvc = k; e.seq_source = ss; e.producer = pr; e.payload = pl;
    if (accepts(svc, tgt)) exp_q.push_back(e);
    else if (exp_drop < 65535) exp_drop++;
  endtask

  task automatic wait_ack(input int bound, output bit g, output int c);
    g = 1'b0; c = 0;
    while (!g && c < bound) begin
      @(negedge clk);
      c++;
      if (br_ack_o) g = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic drop_req();
    br_req_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [1:0] svc, input logic [15:0] tgt, input logic [31:0] pl);
    bit g; int c;
    raise(svc, tgt, 8'h10 + 8'(svc), pl[15:0], ~pl[15:0], pl);
    wait_ack(50, g, c);
    chk("send_ack", g, 1);
    drop_req();
  endtask

  task automatic pop();
    br_svc_ack_i = 1'b1;
    @(posedge clk); #1;
    br_svc_ack_i = 1'b0;
  endtask

  // Monitor: every pop the DUT honours must deliver the oldest expected entry.
  always @(negedge clk) begin
    if (rst_ni && br_svc_ack_i && br_svc_rx_o) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL pop_data: actual=%0h required=<no entry expected>", br_svc_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pop_data", br_svc_data_o, mon_e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", br_ack_o, 0);
    chk("rst_rx", br_svc_rx_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_drop", drop_cnt_o, 0);
    chk("rst_data", br_svc_data_o, 0);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // Single ALL packet with latency check
    raise(2'd0, 16'h0000, 8'h21, 16'h0302, 16'h0105, 32'hDEADBEEF);
    wait_ack(10, got, cyc);
    chk("t1_ack", got, 1);
    chk("t1_ack_latency", cyc, 2);
    chk("t1_rx", br_svc_rx_o, 1);
    chk("t1_level", level_o, 1);
    drop_req();
    pop();
    chk("t1_rx_after_pop", br_svc_rx_o, 0);
    chk("t1_level_after_pop", level_o, 0);

    // Filter: only matching TARGET is queued
    send(2'd1, ADDR, 32'h200);
    send(2'd1, ADDR + 16'd1, 32'h201);
    send(2'd2, ADDR, 32'h202);
    send(2'd3, ADDR, 32'h203);
    chk("t2_drop", drop_cnt_o, exp_drop);
    chk("t2_drop_abs", drop_cnt_o, 3);
    chk("t2_level", level_o, 1);
    pop();
    chk("t2_level_after_pop", level_o, 0);

    // Fill, backpressure, wrap
    for (int i = 0; i < 8; i++) send(2'd0, 16'h0, 32'(i));
    chk("t3_level_full", level_o, 8);
    raise(2'd0, 16'h0, 8'h10, 16'h8, ~16'h8, 32'd8);
    wait_ack(20, got, cyc);
    chk("t3_no_ack_full", got, 0);
    chk("t3_level_still_full", level_o, 8);
    pop();
    wait_ack(3, got, cyc);
    chk("t3_ack_after_pop", got, 1);
    chk("t3_ack_within_2", (cyc <= 2), 1);
    drop_req();
    chk("t3_level_refull", level_o, 8);
    repeat (8) pop();
    chk("t3_level_drained", level_o, 0);

    // Full with simultaneous pop and req
    for (int i = 0; i < 8; i++) send(2'd0, 16'h0, 32'h100 + 32'(i));
    raise(2'd0, 16'h0, 8'h10, 16'h1FF, ~16'h1FF, 32'h1FF);
    br_svc_ack_i = 1'b1;
    @(negedge clk);
    chk("t4_no_ack_pre", br_ack_o, 0);
    @(posedge clk); #1;
    br_svc_ack_i = 1'b0;
    wait_ack(3, got, cyc);
    chk("t4_ack_next", got, 1);
    chk("t4_ack_one_late", cyc, 2);
    chk("t4_level_full", level_o, 8);
    drop_req();
    repeat (8) pop();
    chk("t4_level_drained", level_o, 0);

    // Half full with simultaneous push and pop
    for (int i = 0; i < 4; i++) send(2'd0, 16'h0, 32'h300 + 32'(i));
    raise(2'd0, 16'h0, 8'h10, 16'h304, ~16'h304, 32'h304);
    br_svc_ack_i = 1'b1;
    @(posedge clk); #1;
    br_svc_ack_i = 1'b0;
    wait_ack(3, got, cyc);
    chk("t4b_ack", got, 1);
    chk("t4b_level", level_o, 4);
    drop_req();
    repeat (4) pop();
    chk("t4b_level_drained", level_o, 0);

    // Long-held request accepted exactly once
    raise(2'd0, 16'h0, 8'h10, 16'h400, ~16'h400, 32'h400);
    wait_ack(10, got, cyc);
    chk("t5_ack", got, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t5_no_reack", br_ack_o, 0);
      @(posedge clk); #1;
    end
    chk("t5_level_once", level_o, 1);
    drop_req();
    send(2'd0, 16'h0, 32'h401);
    chk("t5_level_next", level_o, 2);
    repeat (2) pop();

    // Reset during the ACK cycle
    for (int i = 0; i < 3; i++) send(2'd0, 16'h0, 32'h600 + 32'(i));
    raise(2'd0, 16'h0, 8'h10, 16'h604, ~16'h604, 32'h604);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_in_ack", br_ack_o, 1);
    rst_ni = 1'b0;
    @(posedge clk); #1;
    chk("t6_rst_ack", br_ack_o, 0);
    chk("t6_rst_rx", br_svc_rx_o, 0);
    chk("t6_rst_level", level_o, 0);
    chk("t6_rst_drop", drop_cnt_o, 0);
    chk("t6_rst_data", br_svc_data_o, 0);
    exp_q.delete();
    exp_drop = 0;
    rst_ni = 1'b1;
    raise(2'd0, 16'h0, 8'h10, 16'h604, ~16'h604, 32'h604);
    wait_ack(10, got, cyc);
    chk("t6_reaccept", got, 1);
    chk("t6_level_one", level_o, 1);
    drop_req();
    pop();
    pop();
    chk("t6_empty_pop_level", level_o, 0);
    chk("t6_empty_pop_rx", br_svc_rx_o, 0);

    // Randomized traffic with concurrent random pops
    fork
      begin
        for (int n = 0; n < 60; n++) begin
          logic [1:0]  rs;
          logic [15:0] rt;
          bit          g;
          int          c;
          rs = 2'($urandom_range(0, 3));
          rt = ($urandom_range(0, 1) == 1) ? ADDR : 16'($urandom);
          raise(rs, rt, 8'($urandom), 16'($urandom), 16'($urandom), $urandom);
          wait_ack(300, g, c);
          chk("rnd_ack", g, 1);
          drop_req();
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          br_svc_ack_i = ($urandom_range(0, 2) == 0);
          @(posedge clk); #1;
        end
        br_svc_ack_i = 1'b0;
      end
    join
    for (int i = 0; i < 20 && br_svc_rx_o; i++) pop();
    chk("rnd_level_drained", level_o, 0);
    chk("rnd_model_drained", exp_q.size(), 0);
    chk("rnd_drop", drop_cnt_o, exp_drop);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
